// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared accelerator memory port: burst ownership with a
// watchdog on burst length, owner mux onto the port and per-requester read-valid.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        rvalid,
    output logic                    busy,
    output logic                    timeout_evt
);
    localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
    localparam int               IDX_W     = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN, REL} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] addr_q, addr_d, owner_addr;
    logic [DATA_W-1:0] wdata_q, wdata_d, owner_wdata;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              beat;

    // gnt is only non-zero in OWN, so a beat is simply the owner still requesting.
    assign beat = |(req & gnt_q);

    // Scan starts just after the last owner, so the previous owner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && req[(int'(rr_ptr_q) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= IDX_W'(N_REQ - 1);
            beat_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // NOTE: no reset here; these only hold the last beat's address/data, which is don't-care.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        timeout_d  = 1'b0;
        rvalid_d   = {N_REQ{beat}} & gnt_q & ~req_we;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = OWN;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    beat_cnt_d     = '0;
                end
            end
            OWN: begin
                if (!beat) begin
                    state_d = REL;
                    gnt_d   = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d   = REL;
                        gnt_d     = '0;
                        timeout_d = 1'b1;
                    end
                end
            end
            REL: begin
                rr_ptr_d = owner_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_addr  = req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
        owner_wdata = req_wdata[int'(owner_q)*DATA_W +: DATA_W];
        addr_d      = beat ? owner_addr : addr_q;
        wdata_d     = beat ? owner_wdata : wdata_q;
        mem_en      = beat;
        mem_we      = beat & req_we[owner_q];
        mem_addr    = addr_d;
        mem_wdata   = wdata_d;
        rdata       = mem_rdata;
        busy        = (state_q != IDLE);
        gnt         = gnt_q;
        rvalid      = rvalid_q;
        timeout_evt = timeout_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand-written reset and random-traffic sequences for
// mem_port_arbiter with N_REQ=3 and MAX_BURST=4.
module tb_mem_port_arbiter;
    localparam logic [15:0] A0  = 16'h0010;
    localparam logic [15:0] A1  = 16'h0100;
    localparam logic [15:0] A2  = 16'h0200;
    localparam logic [31:0] RD0 = 32'hBEEF_0010;
    localparam logic [31:0] RD1 = 32'hBEEF_0100;
    localparam logic [31:0] RD2 = 32'hBEEF_0200;
    localparam int          WORST_WAIT = 2 * (4 + 2) + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, req_we;
    logic [47:0] req_addr;
    logic [95:0] req_wdata;
    logic [2:0]  gnt, rvalid;
    logic        mem_en, mem_we, busy, timeout_evt;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(32), .N_REQ(3), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory: read data tags the address it was issued to.
    always @(posedge clk) mem_rdata <= {16'hBEEF, mem_addr};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [2:0]  req, we;
        logic [15:0] a1;
        logic [31:0] wd;
        logic [2:0]  gnt;
        logic        en, mwe;
        logic [15:0] maddr;
        logic [31:0] mwd;
        logic [2:0]  rv;
        logic        busy, tmo;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];
    bit   seg_rst[int];

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w, input logic [15:0] a1,
                                input logic [31:0] wd, input logic [2:0] g, input logic en,
                                input logic mwe, input logic [15:0] ma, input logic [31:0] mwd,
                                input logic [2:0] rv, input logic bz, input logic tmo,
                                input logic [31:0] rd);
        vec_t v;
        v.req = r; v.we = w; v.a1 = a1; v.wd = wd; v.gnt = g; v.en = en; v.mwe = mwe;
        v.maddr = ma; v.mwd = mwd; v.rv = rv; v.busy = bz; v.tmo = tmo; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_v(input logic [2:0] r);
        vecs.push_back(mk(r, 3'b000, A1, 32'h0, 3'b000, 0, 0, 16'h0, 32'h0, 3'b000, 0, 0, 32'h0));
    endtask

    initial begin
        int vw[3];
        bit waiting[3];
        int max_wait, v_oh, v_en, v_mux, grants, o;

        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // T1: single read burst of three beats by requester 0.
        seg_rst[vecs.size()] = 1'b1;
        idle_v(3'b001);
        vecs.push_back(mk(3'b001, 3'b000, A1, 0, 3'b001, 1, 0, A0, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b001, 3'b000, A1, 0, 3'b001, 1, 0, A0, 0, 3'b001, 1, 0, RD0));
        vecs.push_back(mk(3'b001, 3'b000, A1, 0, 3'b001, 1, 0, A0, 0, 3'b001, 1, 0, RD0));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b001, 0, 0, 0, 0, 3'b001, 1, 0, RD0));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 0, 0));
        idle_v(3'b000);
        // T2: all three request continuously; each burst hits the cap.
        seg_rst[vecs.size()] = 1'b1;
        idle_v(3'b111);
        for (int r = 0; r < 3; r++) begin
            logic [2:0]  g;
            logic [15:0] ma;
            logic [31:0] rd;
            g  = 3'b001 << r;
            ma = (r == 0) ? A0 : (r == 1) ? A1 : A2;
            rd = (r == 0) ? RD0 : (r == 1) ? RD1 : RD2;
            if (r != 0) idle_v(3'b111);
            vecs.push_back(mk(3'b111, 3'b000, A1, 0, g, 1, 0, ma, 0, 3'b000, 1, 0, 0));
            for (int b = 0; b < 3; b++)
                vecs.push_back(mk(3'b111, 3'b000, A1, 0, g, 1, 0, ma, 0, g, 1, 0, rd));
            vecs.push_back(mk(3'b111, 3'b000, A1, 0, 3'b000, 0, 0, 0, 0, g, 1, 1, rd));
        end
        idle_v(3'b111);
        vecs.push_back(mk(3'b001, 3'b000, A1, 0, 3'b001, 1, 0, A0, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b001, 0, 0, 0, 0, 3'b001, 1, 0, RD0));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 0, 0));
        idle_v(3'b000);
        // T4: requester 1 drops req exactly when beat_cnt has reached MAX_BURST-1.
        idle_v(3'b010);
        vecs.push_back(mk(3'b010, 3'b000, A1, 0, 3'b010, 1, 0, A1, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b010, 3'b000, A1, 0, 3'b010, 1, 0, A1, 0, 3'b010, 1, 0, RD1));
        vecs.push_back(mk(3'b010, 3'b000, A1, 0, 3'b010, 1, 0, A1, 0, 3'b010, 1, 0, RD1));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b010, 0, 0, 0, 0, 3'b010, 1, 0, RD1));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 0, 0));
        idle_v(3'b000);
        // T3: requester 1 write burst; requester 0 arrives mid-burst and waits.
        vecs.push_back(mk(3'b010, 3'b010, 16'h0100, 32'hA5A5_0000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(3'b010, 3'b010, 16'h0100, 32'hA5A5_0000, 3'b010, 1, 1, 16'h0100, 32'hA5A5_0000, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b011, 3'b010, 16'h0101, 32'hA5A5_0001, 3'b010, 1, 1, 16'h0101, 32'hA5A5_0001, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b011, 3'b010, 16'h0102, 32'hA5A5_0002, 3'b010, 1, 1, 16'h0102, 32'hA5A5_0002, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b001, 3'b010, 16'h0102, 32'hA5A5_0002, 3'b010, 0, 0, 0, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b001, 3'b000, A1, 0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 0, 0));
        idle_v(3'b001);
        vecs.push_back(mk(3'b001, 3'b000, A1, 0, 3'b001, 1, 0, A0, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b001, 0, 0, 0, 0, 3'b001, 1, 0, RD0));
        vecs.push_back(mk(3'b000, 3'b000, A1, 0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 0, 0));
        idle_v(3'b000);

        // Reset state, observed while rst is held low across clock edges.
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 3'b000);
        check("rst_rvalid", rvalid, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout_evt, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (seg_rst.exists(i)) do_reset();
            @(negedge clk);
            req       = vecs[i].req;
            req_we    = vecs[i].we;
            req_addr  = {A2, vecs[i].a1, A0};
            req_wdata = {vecs[i].wd ^ 32'h0F0F_0F0F, vecs[i].wd, ~vecs[i].wd};
            #1;
            check($sformatf("v%0d_gnt", i), gnt, vecs[i].gnt);
            check($sformatf("v%0d_mem_en", i), mem_en, vecs[i].en);
            check($sformatf("v%0d_rvalid", i), rvalid, vecs[i].rv);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_timeout", i), timeout_evt, vecs[i].tmo);
            if (vecs[i].en) begin
                check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].mwe);
                check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
                if (vecs[i].mwe) check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].mwd);
            end
            if (vecs[i].rv != 3'b000) check($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
        end

        // T5: asynchronous reset in the middle of a read burst.
        do_reset();
        @(negedge clk);
        req = 3'b001; req_we = 3'b000; req_addr = {A2, A1, A0};
        @(negedge clk); #1;
        check("t5_gnt_before", gnt, 3'b001);
        @(negedge clk); #1;
        check("t5_rvalid_before", rvalid, 3'b001);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t5_gnt_async", gnt, 3'b000);
        check("t5_mem_en_async", mem_en, 1'b0);
        check("t5_rvalid_async", rvalid, 3'b000);
        check("t5_busy_async", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 3'b100;
        #1;
        check("t5_gnt_latency", gnt, 3'b000);
        @(negedge clk); #1;
        check("t5_gnt_req2", gnt, 3'b100);
        check("t5_mem_en_req2", mem_en, 1'b1);
        check("t5_mem_addr_req2", mem_addr, A2);
        check("t5_rvalid_none", rvalid, 3'b000);
        @(negedge clk);
        req = 3'b000;
        repeat (3) @(negedge clk);

        // T6: random traffic; waiting requesters hold req until granted.
        max_wait = 0; v_oh = 0; v_en = 0; v_mux = 0; grants = 0;
        for (int i = 0; i < 3; i++) begin vw[i] = 0; waiting[i] = 1'b0; end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (gnt[i])      req[i] = ($urandom_range(0, 4) != 0);
                else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                req_we[i] = 1'($urandom_range(0, 1));
            end
            req_addr  = {16'($urandom), 16'($urandom), 16'($urandom)};
            req_wdata = {$urandom, $urandom, $urandom};
            #1;
            if (!$onehot0(gnt)) v_oh++;
            if (mem_en !== (|(req & gnt))) v_en++;
            if (mem_en) begin
                o = (gnt[0]) ? 0 : (gnt[1]) ? 1 : 2;
                if (mem_addr !== req_addr[o*16 +: 16] || mem_we !== req_we[o]) v_mux++;
                if (mem_we && mem_wdata !== req_wdata[o*32 +: 32]) v_mux++;
            end
            for (int i = 0; i < 3; i++) begin
                if (gnt[i]) begin
                    if (waiting[i] || vw[i] == 0) grants++;
                    waiting[i] = 1'b0;
                    vw[i] = 0;
                end else if (req[i] && (waiting[i] || !busy)) begin
                    waiting[i] = 1'b1;
                    vw[i]++;
                    if (vw[i] > max_wait) max_wait = vw[i];
                end
            end
        end
        check("t6_onehot_violations", v_oh, 0);
        check("t6_mem_en_violations", v_en, 0);
        check("t6_mux_violations", v_mux, 0);
        check("t6_wait_within_bound", (max_wait <= WORST_WAIT), 1'b1);
        check("t6_grants_seen", (grants > 100), 1'b1);
        req = 3'b000;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
